// File: rtl/tc_pkg.sv
// Shared types, quantiser tables and QP helpers for the 4x4 residual transform loop.
// Pure declarations and functions; no latency or flow control of its own.
package tc_pkg;

  typedef logic signed [7:0] blk4x4_t [0:15];

  typedef enum logic [1:0] {
    POS_A = 2'd0,
    POS_B = 2'd1,
    POS_C = 2'd2
  } pos_class_t;

  localparam logic [5:0] QP_MAX = 6'd51;

  // Indexed [QP%6][position class a,b,c]
  localparam logic [15:0] MF_TAB [0:5][0:2] = '{
    '{16'd13107, 16'd8066, 16'd5243},
    '{16'd11916, 16'd7490, 16'd4660},
    '{16'd10082, 16'd6554, 16'd4194},
    '{16'd9362,  16'd5825, 16'd3647},
    '{16'd8192,  16'd5243, 16'd3355},
    '{16'd7282,  16'd4559, 16'd2893}
  };

  localparam logic [4:0] V_TAB [0:5][0:2] = '{
    '{5'd10, 5'd13, 5'd16},
    '{5'd11, 5'd14, 5'd18},
    '{5'd13, 5'd16, 5'd20},
    '{5'd14, 5'd18, 5'd23},
    '{5'd16, 5'd20, 5'd25},
    '{5'd18, 5'd23, 5'd29}
  };

  function automatic pos_class_t pos_class(input logic [1:0] r, input logic [1:0] c);
    if (!r[0] && !c[0]) return POS_A;
    if (r[0] && c[0])   return POS_C;
    return POS_B;
  endfunction

  function automatic logic [5:0] qp_clamp(input logic [5:0] qp);
    return (qp > QP_MAX) ? QP_MAX : qp;
  endfunction

  function automatic logic [3:0] qpdiv6(input logic [5:0] qp);
    return 4'(qp / 6'd6);
  endfunction

  function automatic logic [2:0] qpmod6(input logic [5:0] qp);
    return 3'(qp % 6'd6);
  endfunction

  function automatic logic [4:0] qbits(input logic [5:0] qp);
    return 5'd15 + 5'(qpdiv6(qp));
  endfunction

endpackage

// File: rtl/transform4x4_1d.sv
// One 4-point integer butterfly, forward (Cf) or inverse (Ci with >>>1 halves).
// Purely combinational; no flow control.
module transform4x4_1d (
  input  logic               inv,
  input  logic signed [31:0] d0,
  input  logic signed [31:0] d1,
  input  logic signed [31:0] d2,
  input  logic signed [31:0] d3,
  output logic signed [31:0] y0,
  output logic signed [31:0] y1,
  output logic signed [31:0] y2,
  output logic signed [31:0] y3
);

  logic signed [31:0] e0, e1, e2, e3;

  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    e3 = '0;
    y0 = '0;
    y1 = '0;
    y2 = '0;
    y3 = '0;
    if (!inv) begin
      e0 = d0 + d3;
      e1 = d1 + d2;
      e2 = d1 - d2;
      e3 = d0 - d3;
      y0 = e0 + e1;
      y1 = (e3 <<< 1) + e2;
      y2 = e0 - e1;
      y3 = e3 - (e2 <<< 1);
    end else begin
      e0 = d0 + d2;
      e1 = d0 - d2;
      e2 = (d1 >>> 1) - d3;
      e3 = d1 + (d3 >>> 1);
      y0 = e0 + e3;
      y1 = e1 + e2;
      y2 = e1 - e2;
      y3 = e0 - e3;
    end
  end

endmodule

// File: rtl/transform_coder.sv
// 4x4 forward transform, quantise, dequantise, inverse transform; each stage loads on its enabler bit.
// Latency 4 enabled edges from residuals to processedres; stages hold when their enable is low.
module transform_coder
  import tc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] enabler,
  input  logic [5:0] QP,
  input  blk4x4_t    residuals,
  output blk4x4_t    processedres
);

  logic signed [15:0] w_q  [0:15];
  logic signed [15:0] z_q  [0:15];
  logic signed [31:0] wd_q [0:15];

  logic signed [31:0] x_ext [0:15];
  logic signed [31:0] fr    [0:15];
  logic signed [31:0] fc    [0:15];
  logic signed [31:0] ir    [0:15];
  logic signed [31:0] ic    [0:15];

  logic signed [15:0] z_nxt   [0:15];
  logic signed [31:0] wd_nxt  [0:15];
  logic signed [7:0]  res_nxt [0:15];

  logic [5:0]  qp_eff;
  logic [3:0]  qdiv;
  logic [2:0]  qmod;
  logic [4:0]  qb;
  logic [31:0] rnd_f;

  assign qp_eff = qp_clamp(QP);
  assign qdiv   = qpdiv6(qp_eff);
  assign qmod   = qpmod6(qp_eff);
  assign qb     = qbits(qp_eff);
  assign rnd_f  = (32'd1 << qb) / 32'd3;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      x_ext[k] = 32'(residuals[k]);
    end
  end

  // Rows first, then columns, in both directions
  for (genvar i = 0; i < 4; i++) begin : g_xf
    transform4x4_1d u_fwd_row (
      .inv(1'b0),
      .d0(x_ext[i*4+0]), .d1(x_ext[i*4+1]), .d2(x_ext[i*4+2]), .d3(x_ext[i*4+3]),
      .y0(fr[i*4+0]),    .y1(fr[i*4+1]),    .y2(fr[i*4+2]),    .y3(fr[i*4+3])
    );
    transform4x4_1d u_fwd_col (
      .inv(1'b0),
      .d0(fr[i]), .d1(fr[4+i]), .d2(fr[8+i]), .d3(fr[12+i]),
      .y0(fc[i]), .y1(fc[4+i]), .y2(fc[8+i]), .y3(fc[12+i])
    );
    transform4x4_1d u_inv_row (
      .inv(1'b1),
      .d0(wd_q[i*4+0]), .d1(wd_q[i*4+1]), .d2(wd_q[i*4+2]), .d3(wd_q[i*4+3]),
      .y0(ir[i*4+0]),   .y1(ir[i*4+1]),   .y2(ir[i*4+2]),   .y3(ir[i*4+3])
    );
    transform4x4_1d u_inv_col (
      .inv(1'b1),
      .d0(ir[i]), .d1(ir[4+i]), .d2(ir[8+i]), .d3(ir[12+i]),
      .y0(ic[i]), .y1(ic[4+i]), .y2(ic[8+i]), .y3(ic[12+i])
    );
  end

  pos_class_t         cls;
  logic signed [31:0] wext;
  logic [31:0]        abs_w;
  logic [31:0]        lvl;
  logic signed [31:0] y_rnd;

  always_comb begin
    cls   = POS_A;
    wext  = '0;
    abs_w = '0;
    lvl   = '0;
    y_rnd = '0;
    for (int k = 0; k < 16; k++) begin
      cls  = pos_class(2'(k >> 2), 2'(k & 3));
      // Quantise magnitude, then restore sign, so rounding is symmetric about zero
      wext  = 32'(w_q[k]);
      abs_w = wext[31] ? -wext : wext;
      lvl   = (abs_w * 32'(MF_TAB[qmod][cls]) + rnd_f) >> qb;
      z_nxt[k]  = wext[31] ? -16'(lvl) : 16'(lvl);
      wd_nxt[k] = (32'(z_q[k]) * $signed({27'd0, V_TAB[qmod][cls]})) <<< qdiv;
      y_rnd = (ic[k] + 32'sd32) >>> 6;
      if (y_rnd > 32'sd127)
        res_nxt[k] = 8'sh7F;
      else if (y_rnd < -32'sd128)
        res_nxt[k] = 8'sh80;
      else
        res_nxt[k] = 8'(y_rnd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        w_q[k]          <= '0;
        z_q[k]          <= '0;
        wd_q[k]         <= '0;
        processedres[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (enabler[0]) w_q[k]          <= 16'(fc[k]);
        if (enabler[1]) z_q[k]          <= z_nxt[k];
        if (enabler[2]) wd_q[k]         <= wd_nxt[k];
        if (enabler[3]) processedres[k] <= res_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_transform_coder.sv
// Directed-vector bench for transform_coder with hand-computed reconstructions.
module tb_transform_coder;
  import tc_pkg::*;

  typedef int iblk_t [0:15];

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enabler;
  logic [5:0] QP;
  blk4x4_t    residuals;
  blk4x4_t    processedres;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  transform_coder dut (
    .clk(clk),
    .reset(reset),
    .enabler(enabler),
    .QP(QP),
    .residuals(residuals),
    .processedres(processedres)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input iblk_t exp);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s[%0d]", tag, k), int'(processedres[k]), exp[k]);
  endtask

  function automatic iblk_t fill(input int v);
    iblk_t b;
    for (int k = 0; k < 16; k++) b[k] = v;
    return b;
  endfunction

  function automatic iblk_t chequer(input int pos, input int neg);
    iblk_t b;
    for (int k = 0; k < 16; k++) b[k] = (((k >> 2) + (k & 3)) % 2 == 0) ? pos : neg;
    return b;
  endfunction

  task automatic load(input iblk_t v, input int qp);
    for (int k = 0; k < 16; k++) residuals[k] = 8'(v[k]);
    QP = 6'(qp);
  endtask

  task automatic tick(input logic [3:0] en);
    @(negedge clk);
    enabler = en;
    @(posedge clk);
    #1;
    enabler = 4'd0;
  endtask

  task automatic walk();
    tick(4'd1);
    tick(4'd2);
    tick(4'd4);
    tick(4'd8);
  endtask

  iblk_t exp_b;

  initial begin
    reset   = 1'b1;
    enabler = 4'd0;
    load(fill(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_blk("reset_out", fill(0));
    check("reset_w0", int'(dut.w_q[0]), 0);
    check("reset_wd0", dut.wd_q[0], 0);

    // DC block of 10: W[0]=160, Z[0]=49, Wd[0]=637, reconstructs to 10
    load(fill(10), 2);
    tick(4'd1);
    check("pos_w0", int'(dut.w_q[0]), 160);
    check("pos_w5", int'(dut.w_q[5]), 0);
    tick(4'd2);
    check("pos_z0", int'(dut.z_q[0]), 49);
    tick(4'd4);
    check("pos_wd0", dut.wd_q[0], 637);
    tick(4'd8);
    check_blk("pos_out", fill(10));

    load(fill(0), 30);
    walk();
    check_blk("zero_out", fill(0));

    load(fill(-10), 2);
    tick(4'd1);
    check("neg_w0", int'(dut.w_q[0]), -160);
    tick(4'd2);
    check("neg_z0", int'(dut.z_q[0]), -49);
    tick(4'd4);
    check("neg_wd0", dut.wd_q[0], -637);
    tick(4'd8);
    check_blk("neg_out", fill(-10));

    // Left column of 20: exercises the a and b position classes at QP 0
    exp_b = '{20, 0, 0, 0, 20, 0, 0, 0, 20, 0, 0, 0, 20, 0, 0, 0};
    load(exp_b, 0);
    walk();
    check_blk("stripe_out", exp_b);

    load(fill(50), 7);
    repeat (5) tick(4'd0);
    check_blk("hold_out", exp_b);
    check("hold_w0", int'(dut.w_q[0]), 80);

    tick(4'd1);
    tick(4'd2);
    @(negedge clk);
    enabler = 4'd4;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    enabler = 4'd0;
    check_blk("rst_mid_out", fill(0));
    check("rst_mid_wd0", dut.wd_q[0], 0);
    tick(4'd8);
    check_blk("rst_stale_out", fill(0));

    load(fill(127), 0);
    walk();
    check_blk("max_out", fill(127));

    exp_b = '{23, -46, 46, -23, -46, 92, -92, 46, 46, -92, 92, -46, -23, 46, -46, 23};
    load(chequer(100, -100), 51);
    walk();
    check_blk("cb51_out", exp_b);

    // QP above 51 must behave exactly like 51
    load(chequer(100, -100), 63);
    walk();
    check_blk("cb63_out", exp_b);

    exp_b = '{46, -92, 92, -46, -92, 127, -128, 92, 92, -128, 127, -92, -46, 92, -92, 46};
    load(chequer(127, -128), 51);
    walk();
    check_blk("sat_out", exp_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
